// File: rtl/fnd_pkg.sv
// Shared constants for the multiplexed 7-segment scanner.
// Holds the hex font and the nibble-to-segment helper used by fnd_scan.
// Segment byte layout: bit7=a, bit6=b ... bit1=g, bit0=dp (active-high).
package fnd_pkg;

   localparam int unsigned SEG_W = 8;
   localparam int unsigned NIB_W = 4;

   // Element k is the active-high pattern for hex digit k (0 at the LSB end).
   localparam logic [15:0][SEG_W-1:0] FONT = {
      8'h8E, 8'h9E, 8'h7A, 8'h9C,   // F E D C
      8'h3E, 8'hEE, 8'hE6, 8'hFE,   // B A 9 8
      8'hE0, 8'hBE, 8'hB6, 8'h66,   // 7 6 5 4
      8'hF2, 8'hDA, 8'h60, 8'hFC    // 3 2 1 0
   };

   // Font lookup with the decimal point merged into bit 0.
   function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIB_W-1:0] nib,
                                                   input logic             dp_on);
      return FONT[nib] | {{(SEG_W-1){1'b0}}, dp_on};
   endfunction

endpackage

// File: rtl/fnd_tick.sv
// Slot timebase: free-running counter 0..TICK_DIV-1 with a terminal-count strobe.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   cnt        : current position inside the slot
//   tick       : high while cnt == TICK_DIV-1 (combinational)
module fnd_tick #(
   parameter  int unsigned CLK_HZ   = 100_000_000,
   parameter  int unsigned SCAN_HZ  = 720,
   localparam int unsigned TICK_DIV = CLK_HZ / SCAN_HZ,
   localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [CNT_W-1:0] cnt,
   output logic             tick
);

   logic [CNT_W-1:0] r_cnt;

   assign tick = (r_cnt == CNT_W'(TICK_DIV - 1));
   assign cnt  = r_cnt;

   // Wrap on terminal count; an enable strobe, not a derived clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_cnt <= '0;
      else if (tick) r_cnt <= '0;
      else           r_cnt <= r_cnt + CNT_W'(1);
   end

endmodule

// File: rtl/fnd_scan.sv
// Multiplexed 7-segment display scanner with frame-synchronous update buffer.
// Ports:
//   clk, rst_n              : system clock, async active-low reset
//   value, dp, blank, lz_en : display content, captured through the load handshake
//   bright                  : live brightness level (on-window length per slot)
//   load_valid / load_ready : update handshake; one pending buffer, applied at frame end
//   frame_start             : one-cycle pulse in the first cycle of slot 0
//   SEG, DIGIT              : registered segment bus and active-low digit selects
module fnd_scan
   import fnd_pkg::*;
#(
   parameter int unsigned N_DIGITS       = 4,
   parameter int unsigned CLK_HZ         = 100_000_000,
   parameter int unsigned SCAN_HZ        = 720,
   parameter int unsigned BRIGHT_W       = 3,
   parameter int unsigned GUARD          = 2,
   parameter int unsigned SEG_ACTIVE_LOW = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]   dp,
   input  logic [N_DIGITS-1:0]   blank,
   input  logic                  lz_en,
   input  logic [BRIGHT_W-1:0]   bright,
   input  logic                  load_valid,
   output logic                  load_ready,
   output logic                  frame_start,
   output logic [SEG_W-1:0]      SEG,
   output logic [N_DIGITS-1:0]   DIGIT
);

   localparam int unsigned TICK_DIV = CLK_HZ / SCAN_HZ;
   localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic [SEG_W-1:0] SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   logic [CNT_W-1:0]      w_cnt;
   logic                  w_tick;
   logic                  w_frame_end;
   logic [31:0]           w_cnt32;
   logic [31:0]           w_lim;
   logic [NIB_W-1:0]      w_nib;
   logic                  w_zero_run;
   logic [N_DIGITS-1:0]   w_supp;
   logic                  w_on;
   logic [SEG_W-1:0]      w_seg_nxt;
   logic [N_DIGITS-1:0]   w_digit_nxt;

   logic [IDX_W-1:0]      r_idx;
   logic                  r_frame_start;
   logic                  r_ready;
   logic [4*N_DIGITS-1:0] r_pd_value;
   logic [N_DIGITS-1:0]   r_pd_dp;
   logic [N_DIGITS-1:0]   r_pd_blank;
   logic                  r_pd_lz;
   logic [4*N_DIGITS-1:0] r_sh_value;
   logic [N_DIGITS-1:0]   r_sh_dp;
   logic [N_DIGITS-1:0]   r_sh_blank;
   logic                  r_sh_lz;
   logic [SEG_W-1:0]      r_seg;
   logic [N_DIGITS-1:0]   r_digit;

   fnd_tick #(
      .CLK_HZ  (CLK_HZ),
      .SCAN_HZ (SCAN_HZ)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .cnt   (w_cnt),
      .tick  (w_tick)
   );

   assign w_frame_end = w_tick && (r_idx == IDX_LAST);

   // Slot index and frame-start pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx         <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= w_frame_end;
         if (w_tick) r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
   end

   // Pending buffer fills on handshake; it is only copied to the shadow at a
   // frame boundary so a frame is never drawn with mixed old/new content.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ready    <= 1'b1;
         r_pd_value <= '0;
         r_pd_dp    <= '0;
         r_pd_blank <= '0;
         r_pd_lz    <= 1'b0;
         r_sh_value <= '0;
         r_sh_dp    <= '0;
         r_sh_blank <= '0;
         r_sh_lz    <= 1'b0;
      end else if (r_ready) begin
         if (load_valid) begin
            r_pd_value <= value;
            r_pd_dp    <= dp;
            r_pd_blank <= blank;
            r_pd_lz    <= lz_en;
            r_ready    <= 1'b0;
         end
      end else if (w_frame_end) begin
         r_sh_value <= r_pd_value;
         r_sh_dp    <= r_pd_dp;
         r_sh_blank <= r_pd_blank;
         r_sh_lz    <= r_pd_lz;
         r_ready    <= 1'b1;
      end
   end

   // Leading-zero mask: scan from the leftmost digit, stop at first non-zero.
   always_comb begin
      w_zero_run = 1'b1;
      w_supp     = '0;
      for (int i = N_DIGITS - 1; i > 0; i--) begin
         if (r_sh_value[4*i +: 4] != 4'h0) w_zero_run = 1'b0;
         w_supp[i] = r_sh_lz & w_zero_run;
      end
   end

   // On-window: guard blanking at slot start, brightness sets the end point.
   always_comb begin
      w_cnt32     = 32'(w_cnt);
      w_lim       = ((32'(bright) + 32'd1) * TICK_DIV) >> BRIGHT_W;
      w_nib       = r_sh_value[4*r_idx +: 4];
      w_on        = (w_cnt32 >= GUARD) && (w_cnt32 < w_lim) &&
                    !r_sh_blank[r_idx] && !w_supp[r_idx];
      w_seg_nxt   = SEG_OFF;
      w_digit_nxt = '1;
      if (w_on) begin
         w_seg_nxt   = hex_to_seg(w_nib, r_sh_dp[r_idx]) ^ SEG_OFF;
         w_digit_nxt = ~(N_DIGITS'(1) << r_idx);
      end
   end

   // Output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg   <= SEG_OFF;
         r_digit <= '1;
      end else begin
         r_seg   <= w_seg_nxt;
         r_digit <= w_digit_nxt;
      end
   end

   assign SEG         = r_seg;
   assign DIGIT       = r_digit;
   assign load_ready  = r_ready;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_fnd_scan.sv
// Self-checking bench for fnd_scan: time-indexed reference model plus directed frames.
module tb_fnd_scan;

   localparam int N        = 4;
   localparam int CLK_HZ   = 1000;
   localparam int SCAN_HZ  = 100;
   localparam int BRIGHT_W = 3;
   localparam int GUARD    = 2;
   localparam int DIV      = CLK_HZ / SCAN_HZ;
   localparam int FRAME    = DIV * N;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   value = '0;
   logic [3:0]    dp = '0;
   logic [3:0]    blank = '0;
   logic          lz_en = 1'b0;
   logic [2:0]    bright = 3'd7;
   logic          load_valid = 1'b0;
   logic          load_ready;
   logic          frame_start;
   logic [7:0]    SEG;
   logic [3:0]    DIGIT;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_on   = 1'b0;

   logic [7:0] font [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                             8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

   fnd_scan #(
      .N_DIGITS       (N),
      .CLK_HZ         (CLK_HZ),
      .SCAN_HZ        (SCAN_HZ),
      .BRIGHT_W       (BRIGHT_W),
      .GUARD          (GUARD),
      .SEG_ACTIVE_LOW (0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .dp          (dp),
      .blank       (blank),
      .lz_en       (lz_en),
      .bright      (bright),
      .load_valid  (load_valid),
      .load_ready  (load_ready),
      .frame_start (frame_start),
      .SEG         (SEG),
      .DIGIT       (DIGIT)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: m_t counts cycles since reset release; slot position and
   // frame boundaries follow from plain division of that count.
   int          m_t;
   logic        m_ready;
   logic [15:0] m_p_val, m_s_val;
   logic [3:0]  m_p_dp, m_s_dp, m_p_blank, m_s_blank;
   logic        m_p_lz, m_s_lz;
   logic [7:0]  exp_seg;
   logic [3:0]  exp_digit;
   logic        exp_fs;

   always @(posedge clk or negedge rst_n) begin : model
      int c, s, lim;
      bit on, supp, last;
      logic [15:0] upper;
      if (!rst_n) begin
         m_t = 0; m_ready = 1'b1;
         m_p_val = '0; m_p_dp = '0; m_p_blank = '0; m_p_lz = 1'b0;
         m_s_val = '0; m_s_dp = '0; m_s_blank = '0; m_s_lz = 1'b0;
         exp_seg = 8'h00; exp_digit = 4'hF; exp_fs = 1'b0;
      end else begin
         c     = m_t % DIV;
         s     = (m_t / DIV) % N;
         last  = (m_t % FRAME) == FRAME - 1;
         lim   = ((int'(bright) + 1) * DIV) >> BRIGHT_W;
         upper = m_s_val >> (4 * s);
         supp  = m_s_lz && (s != 0) && (upper == 16'h0);
         on    = (c >= GUARD) && (c < lim) && !m_s_blank[s] && !supp;
         exp_digit = on ? ~(4'b0001 << s) : 4'hF;
         exp_seg   = on ? (font[upper[3:0]] | {7'b0, m_s_dp[s]}) : 8'h00;
         exp_fs    = last;
         if (m_ready && load_valid) begin
            m_p_val = value; m_p_dp = dp; m_p_blank = blank; m_p_lz = lz_en;
            m_ready = 1'b0;
         end else if (!m_ready && last) begin
            m_s_val = m_p_val; m_s_dp = m_p_dp; m_s_blank = m_p_blank; m_s_lz = m_p_lz;
            m_ready = 1'b1;
         end
         m_t++;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(posedge clk) begin
      #1;
      if (chk_on) begin
         chk("seg", SEG, exp_seg);
         chk("digit", DIGIT, exp_digit);
         chk("frame_start", frame_start, exp_fs);
         chk("load_ready", load_ready, m_ready);
      end
   end

   int         obs_on [4];
   logic [7:0] obs_seg [4];

   task automatic wait_fs();
      for (int k = 0; k < 3 * FRAME; k++) begin
         @(posedge clk); #1;
         if (frame_start) return;
      end
      chk("wait_frame_start", frame_start, 1);
   endtask

   // Collect the lit cycles and lit SEG per digit over the frame after frame_start.
   task automatic observe_frame();
      for (int d = 0; d < N; d++) begin obs_on[d] = 0; obs_seg[d] = 8'h00; end
      for (int k = 0; k < FRAME; k++) begin
         @(posedge clk); #1;
         for (int d = 0; d < N; d++)
            if (!DIGIT[d]) begin obs_on[d]++; obs_seg[d] = SEG; end
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] p,
                          input logic [3:0] b, input logic lz);
      @(negedge clk);
      value = v; dp = p; blank = b; lz_en = lz; load_valid = 1'b1;
      for (int k = 0; k < 3 * FRAME; k++) begin
         if (load_ready) begin
            @(negedge clk);
            load_valid = 1'b0;
            chk("ready_low_after_accept", load_ready, 0);
            return;
         end
         @(negedge clk);
      end
      chk("load_accept", load_ready, 1);
      load_valid = 1'b0;
   endtask

   task automatic chk_frame(input string tag, input int on0, input int on1,
                            input int on2, input int on3);
      chk({tag, "_on0"}, obs_on[0], on0);
      chk({tag, "_on1"}, obs_on[1], on1);
      chk({tag, "_on2"}, obs_on[2], on2);
      chk({tag, "_on3"}, obs_on[3], on3);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_digit", DIGIT, 4'hF);
      chk("rst_seg", SEG, 8'h00);
      chk("rst_ready", load_ready, 1);
      chk("rst_fs", frame_start, 0);
      rst_n  = 1'b1;
      chk_on = 1'b1;

      // Plain content, full brightness, then reduced windows.
      bright = 3'd7;
      do_load(16'h2039, 4'b0000, 4'b0000, 1'b0);
      wait_fs(); observe_frame();
      chk_frame("b7", 8, 8, 8, 8);
      chk("b7_seg0", obs_seg[0], 8'hE6);
      chk("b7_seg1", obs_seg[1], 8'hF2);
      chk("b7_seg2", obs_seg[2], 8'hFC);
      chk("b7_seg3", obs_seg[3], 8'hDA);
      @(negedge clk); bright = 3'd3;
      wait_fs(); observe_frame();
      chk_frame("b3", 3, 3, 3, 3);
      @(negedge clk); bright = 3'd0;
      wait_fs(); observe_frame();
      chk_frame("b0", 0, 0, 0, 0);

      // Leading-zero suppression.
      @(negedge clk); bright = 3'd7;
      do_load(16'h0050, 4'b0000, 4'b0000, 1'b1);
      wait_fs(); observe_frame();
      chk_frame("lz", 8, 8, 0, 0);
      chk("lz_seg0", obs_seg[0], 8'hFC);
      chk("lz_seg1", obs_seg[1], 8'hB6);

      // Decimal point and blanking.
      do_load(16'h2039, 4'b0100, 4'b0001, 1'b0);
      wait_fs(); observe_frame();
      chk_frame("dpbl", 0, 8, 8, 8);
      chk("dpbl_seg2", obs_seg[2], 8'hFD);

      // Mid-frame load in slot 1: held until the boundary.
      wait_fs();
      repeat (DIV + 3) @(negedge clk);
      do_load(16'h1234, 4'b0000, 4'b0000, 1'b0);
      wait_fs();
      chk("mid_ready_after_boundary", load_ready, 1);
      observe_frame();
      chk("mid_seg0", obs_seg[0], 8'h66);
      chk("mid_seg3", obs_seg[3], 8'h60);

      // Randomized content, brightness and load spacing.
      for (int i = 0; i < 40; i++) begin
         @(negedge clk); bright = 3'($urandom_range(0, 7));
         repeat ($urandom_range(0, 30)) @(negedge clk);
         do_load(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      end

      // Reset in slot 2 with a load pending.
      wait_fs();
      @(negedge clk); bright = 3'd7;
      repeat (2 * DIV + 3) @(negedge clk);
      do_load(16'h8888, 4'b1111, 4'b0000, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_digit", DIGIT, 4'hF);
      chk("mid_rst_seg", SEG, 8'h00);
      chk("mid_rst_ready", load_ready, 1);
      chk("mid_rst_fs", frame_start, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_fs(); observe_frame();
      chk_frame("post_rst", 8, 8, 8, 8);
      chk("post_rst_seg0", obs_seg[0], 8'hFC);
      chk("post_rst_seg3", obs_seg[3], 8'hFC);

      repeat (5) @(negedge clk);
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
